// File: rtl/cpu_defs.sv
// Shared definitions for the BusArchitecture CPU control path: opcodes, sequencer
// states, instruction classes and IR field positions.
package cpu_defs;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  // state_dbg exposes these codes directly.
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU2,
    C_MULDIV,
    C_ALU1,
    C_MFLO,
    C_NOP,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  // Bit positions inside the one-hot ALU strobe vector.
  localparam int unsigned ALU_W      = 12;
  localparam int unsigned ALU_ADD    = 0;
  localparam int unsigned ALU_SUB    = 1;
  localparam int unsigned ALU_MUL    = 2;
  localparam int unsigned ALU_DIV    = 3;
  localparam int unsigned ALU_SHR    = 4;
  localparam int unsigned ALU_SHL    = 5;
  localparam int unsigned ALU_ROR    = 6;
  localparam int unsigned ALU_ROL    = 7;
  localparam int unsigned ALU_AND    = 8;
  localparam int unsigned ALU_OR     = 9;
  localparam int unsigned ALU_NEGATE = 10;
  localparam int unsigned ALU_NOT    = 11;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: IR value in, every datapath strobe out.
interface control_unit_if #(
  parameter int unsigned BITS = 32
);
  logic [BITS-1:0] ir;

  logic PCout, MDRout, RZout, HILOout, Rout, Cout, INPUTout, INTERout, BAout;
  logic PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, INTERin, Rin;
  logic Gra, Grb, Grc;
  logic Read, Write, IncPC;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
  logic halted, illegal;
  logic [3:0] state_dbg;

  modport master (
    input  ir,
    output PCout, MDRout, RZout, HILOout, Rout, Cout, INPUTout, INTERout, BAout,
    output PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, INTERin, Rin,
    output Gra, Grb, Grc, Read, Write, IncPC,
    output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
    output halted, illegal, state_dbg
  );

  modport slave (
    output ir,
    input  PCout, MDRout, RZout, HILOout, Rout, Cout, INPUTout, INTERout, BAout,
    input  PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, OUTPUTin, INTERin, Rin,
    input  Gra, Grb, Grc, Read, Write, IncPC,
    input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
    input  halted, illegal, state_dbg
  );
endinterface

// File: rtl/control_decode.sv
// Opcode decoder: instruction class plus the one-hot ALU strobe for that opcode.
module control_decode
  import cpu_defs::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0]   op,
  output iclass_t          iclass,
  output logic [ALU_W-1:0] alu_op
);

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = '0;
    case (op)
      OP_ADD:  begin iclass = C_ALU2;   alu_op[ALU_ADD]    = 1'b1; end
      OP_SUB:  begin iclass = C_ALU2;   alu_op[ALU_SUB]    = 1'b1; end
      OP_SHR:  begin iclass = C_ALU2;   alu_op[ALU_SHR]    = 1'b1; end
      OP_SHL:  begin iclass = C_ALU2;   alu_op[ALU_SHL]    = 1'b1; end
      OP_ROR:  begin iclass = C_ALU2;   alu_op[ALU_ROR]    = 1'b1; end
      OP_ROL:  begin iclass = C_ALU2;   alu_op[ALU_ROL]    = 1'b1; end
      OP_AND:  begin iclass = C_ALU2;   alu_op[ALU_AND]    = 1'b1; end
      OP_OR:   begin iclass = C_ALU2;   alu_op[ALU_OR]     = 1'b1; end
      OP_MUL:  begin iclass = C_MULDIV; alu_op[ALU_MUL]    = 1'b1; end
      OP_DIV:  begin iclass = C_MULDIV; alu_op[ALU_DIV]    = 1'b1; end
      OP_NEG:  begin iclass = C_ALU1;   alu_op[ALU_NEGATE] = 1'b1; end
      OP_NOT:  begin iclass = C_ALU1;   alu_op[ALU_NOT]    = 1'b1; end
      OP_MFLO: iclass = C_MFLO;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, class-dependent execute T3-T5, HALT until reset.
module control_unit
  import cpu_defs::*;
#(
  parameter int unsigned BITS = 32,
  parameter int unsigned OPW  = 5
) (
  input logic           clk,
  input logic           reset,
  control_unit_if.master bus
);

  state_t           state_q, state_d;
  iclass_t          iclass;
  logic [ALU_W-1:0] alu_op;

  control_decode #(
    .OPW (OPW)
  ) u_decode (
    .op     (bus.ir[BITS-1 -: OPW]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.RZout = 1'b0; bus.HILOout = 1'b0;
    bus.Rout = 1'b0; bus.Cout = 1'b0; bus.INPUTout = 1'b0; bus.INTERout = 1'b0;
    bus.BAout = 1'b0;
    bus.PCin = 1'b0; bus.IRin = 1'b0; bus.RYin = 1'b0; bus.RZin = 1'b0; bus.MARin = 1'b0;
    bus.MDRin = 1'b0; bus.HILOin = 1'b0; bus.CONin = 1'b0; bus.OUTPUTin = 1'b0;
    bus.INTERin = 1'b0; bus.Rin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0; bus.IncPC = 1'b0;
    {bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL, bus.ROR,
     bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD} = '0;
    bus.halted = 1'b0;
    bus.illegal = 1'b0;
    bus.state_dbg = state_q;

    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.RZin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        bus.RZout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        case (iclass)
          C_ALU2: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1;
            state_d = S_T4;
          end
          C_MULDIV: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1;
            state_d = S_T4;
          end
          C_ALU1: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RZin = 1'b1;
            {bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL, bus.ROR,
             bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD} = alu_op;
            state_d = S_T4;
          end
          C_MFLO: begin
            bus.HILOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_HALT:    state_d = S_HALT;
          C_ILLEGAL: bus.illegal = 1'b1;
          default:   ;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (iclass)
          C_ALU2: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.RZin = 1'b1;
            {bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL, bus.ROR,
             bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD} = alu_op;
          end
          C_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RZin = 1'b1;
            {bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL, bus.ROR,
             bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD} = alu_op;
          end
          C_ALU1: begin
            bus.RZout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            state_d = S_T0;
          end
          // IR changed under a multi-cycle instruction: abandon it quietly.
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (iclass)
          C_ALU2:   begin bus.RZout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MULDIV: begin bus.RZout = 1'b1; bus.HILOin = 1'b1; end
          default:  ;
        endcase
      end
      S_HALT: bus.halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table, reset corners and random opcodes
// checked cycle by cycle against a per-instruction strobe-list model.
module tb_control_unit;

  localparam int B_PCOUT = 0, B_MDROUT = 1, B_RZOUT = 2, B_HILOOUT = 3, B_ROUT = 4;
  localparam int B_PCIN = 9, B_IRIN = 10, B_RYIN = 11, B_RZIN = 12, B_MARIN = 13;
  localparam int B_MDRIN = 14, B_HILOIN = 15, B_RIN = 19;
  localparam int B_GRA = 20, B_GRB = 21, B_GRC = 22, B_READ = 23, B_INCPC = 25;
  localparam int B_ADD = 26, B_SUB = 27, B_MUL = 28, B_DIV = 29, B_SHR = 30, B_SHL = 31;
  localparam int B_ROR = 32, B_ROL = 33, B_AND = 34, B_OR = 35, B_NEGATE = 36, B_NOT = 37;
  localparam int B_HALTED = 38, B_ILLEGAL = 39;

  localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3;
  localparam logic [3:0] ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_HALT = 4'd7;

  typedef struct {
    logic [39:0] v;
    logic [3:0]  st;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [39:0] t3;
    int          cycles;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  step_t exp_q[$];
  logic [39:0] obs;

  control_unit_if #(.BITS(32)) bus ();

  control_unit #(.BITS(32), .OPW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign obs = {bus.illegal, bus.halted, bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL,
                bus.ROR, bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD,
                bus.IncPC, bus.Write, bus.Read, bus.Grc, bus.Grb, bus.Gra,
                bus.Rin, bus.INTERin, bus.OUTPUTin, bus.CONin, bus.HILOin, bus.MDRin,
                bus.MARin, bus.RZin, bus.RYin, bus.IRin, bus.PCin,
                bus.BAout, bus.INTERout, bus.INPUTout, bus.Cout, bus.Rout, bus.HILOout,
                bus.RZout, bus.MDRout, bus.PCout};

  function automatic logic [39:0] bv(input int i);
    return 40'd1 << i;
  endfunction

  function automatic void push(input logic [3:0] st, input logic [39:0] v);
    step_t s;
    s.st = st;
    s.v = v;
    exp_q.push_back(s);
  endfunction

  // Expected strobe list for one instruction, fetch included, straight from the opcode table.
  function automatic void model(input logic [4:0] op);
    int alu;
    exp_q.delete();
    push(ST_T0, bv(B_PCOUT) | bv(B_MARIN) | bv(B_INCPC) | bv(B_RZIN));
    push(ST_T1, bv(B_RZOUT) | bv(B_PCIN) | bv(B_READ) | bv(B_MDRIN));
    push(ST_T2, bv(B_MDROUT) | bv(B_IRIN));
    case (op)
      5'd3: alu = B_ADD;  5'd4: alu = B_SUB;  5'd5: alu = B_SHR;  5'd6: alu = B_SHL;
      5'd7: alu = B_ROR;  5'd8: alu = B_ROL;  5'd9: alu = B_AND;  5'd10: alu = B_OR;
      5'd14: alu = B_MUL; 5'd15: alu = B_DIV; 5'd16: alu = B_NEGATE; 5'd17: alu = B_NOT;
      default: alu = -1;
    endcase
    if (op >= 5'd3 && op <= 5'd10) begin
      push(ST_T3, bv(B_GRB) | bv(B_ROUT) | bv(B_RYIN));
      push(ST_T4, bv(B_GRC) | bv(B_ROUT) | bv(alu) | bv(B_RZIN));
      push(ST_T5, bv(B_RZOUT) | bv(B_GRA) | bv(B_RIN));
    end else if (op == 5'd14 || op == 5'd15) begin
      push(ST_T3, bv(B_GRA) | bv(B_ROUT) | bv(B_RYIN));
      push(ST_T4, bv(B_GRB) | bv(B_ROUT) | bv(alu) | bv(B_RZIN));
      push(ST_T5, bv(B_RZOUT) | bv(B_HILOIN));
    end else if (op == 5'd16 || op == 5'd17) begin
      push(ST_T3, bv(B_GRB) | bv(B_ROUT) | bv(alu) | bv(B_RZIN));
      push(ST_T4, bv(B_RZOUT) | bv(B_GRA) | bv(B_RIN));
    end else if (op == 5'd24) begin
      push(ST_T3, bv(B_HILOOUT) | bv(B_GRA) | bv(B_RIN));
    end else if (op == 5'd25 || op == 5'd26) begin
      push(ST_T3, 40'd0);
    end else begin
      push(ST_T3, bv(B_ILLEGAL));
    end
  endfunction

  task automatic chk_v(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s strobes got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in T0; returns at the negedge after the last step.
  task automatic run_instr(input string name, input logic [31:0] ir, output logic [39:0] t3v);
    bus.ir = ir;
    model(ir[31:27]);
    t3v = '0;
    foreach (exp_q[i]) begin
      chk_s(name, bus.state_dbg, exp_q[i].st);
      chk_v(name, obs, exp_q[i].v);
      if (i == 3) t3v = obs;
      @(negedge clk);
    end
  endtask

  vec_t tbl[9];
  logic [39:0] t3v;

  initial begin
    tbl[0] = '{"add",  32'h18918000, bv(B_GRB) | bv(B_ROUT) | bv(B_RYIN), 6};
    tbl[1] = '{"mul",  32'h71A00000, bv(B_GRA) | bv(B_ROUT) | bv(B_RYIN), 6};
    tbl[2] = '{"div",  32'h78000000, bv(B_GRA) | bv(B_ROUT) | bv(B_RYIN), 6};
    tbl[3] = '{"or",   32'h50918000, bv(B_GRB) | bv(B_ROUT) | bv(B_RYIN), 6};
    tbl[4] = '{"neg",  32'h80900000, bv(B_GRB) | bv(B_ROUT) | bv(B_NEGATE) | bv(B_RZIN), 5};
    tbl[5] = '{"not",  32'h88900000, bv(B_GRB) | bv(B_ROUT) | bv(B_NOT) | bv(B_RZIN), 5};
    tbl[6] = '{"mflo", 32'hC1000000, bv(B_HILOOUT) | bv(B_GRA) | bv(B_RIN), 4};
    tbl[7] = '{"nop",  32'hC8000000, 40'd0, 4};
    tbl[8] = '{"ill",  32'hF8000000, bv(B_ILLEGAL), 4};

    bus.ir = '0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_s("reset_hold", bus.state_dbg, ST_RST);
      chk_v("reset_hold", obs, 40'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_instr(tbl[k].name, tbl[k].ir, t3v);
      chk_v({tbl[k].name, "_t3"}, t3v, tbl[k].t3);
      // One more cycle count than the table says would leave us mid-instruction.
      checks++;
      if (exp_q.size() != tbl[k].cycles || bus.state_dbg !== ST_T0) begin
        errors++;
        $display("FAIL %s_len got %0d cycles state %0d want %0d cycles back in T0",
                 tbl[k].name, exp_q.size(), bus.state_dbg, tbl[k].cycles);
      end
    end

    // Reset during T4 of add: no Rin, then a clean refetch.
    bus.ir = 32'h18918000;
    model(5'd3);
    for (int i = 0; i < 5; i++) begin
      chk_s("rst_mid", bus.state_dbg, exp_q[i].st);
      chk_v("rst_mid", obs, exp_q[i].v);
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_s("rst_mid_abort", bus.state_dbg, ST_RST);
    chk_v("rst_mid_abort", obs, 40'd0);
    reset = 1'b0;
    @(negedge clk);
    run_instr("refetch", 32'h18918000, t3v);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      run_instr("rand", {op, 27'($urandom)}, t3v);
    end

    run_instr("ill2", 32'hF8000000, t3v);
    run_instr("halt", 32'hD0000000, t3v);
    for (int i = 0; i < 20; i++) begin
      chk_s("halt_hold", bus.state_dbg, ST_HALT);
      chk_v("halt_hold", obs, bv(B_HALTED));
      @(negedge clk);
    end

    reset = 1'b1;
    @(negedge clk);
    chk_s("halt_reset", bus.state_dbg, ST_RST);
    reset = 1'b0;
    @(negedge clk);
    run_instr("post_halt", 32'hC8000000, t3v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
